// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline definitions: operand-source select codes and the hazard scoreboard slot.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    typedef logic [2:0] src_sel_t;

    localparam src_sel_t SRC_WB      = 3'b000;
    localparam src_sel_t SRC_EX_ALU  = 3'b001;
    localparam src_sel_t SRC_REGFILE = 3'b010;
    localparam src_sel_t SRC_EX_IN   = 3'b011;
    localparam src_sel_t SRC_MEM_IN  = 3'b100;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  writes_rd;
        logic                  is_load;
        logic                  is_in;
    } sb_slot_t;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Decode-side hazard request and ID/EX forwarding result bundle.
interface forward_hazard_unit_if
    import pipeline_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) ();

    logic                   id_valid;
    logic [REG_ADDR_W-1:0]  id_rs1;
    logic [REG_ADDR_W-1:0]  id_rs2;
    logic                   id_uses_rs1;
    logic                   id_uses_rs2;
    logic [REG_ADDR_W-1:0]  id_rd;
    logic                   id_writes_rd;
    logic                   id_is_load;
    logic                   id_is_in;
    logic                   flush;
    logic                   stall;
    src_sel_t               alu_src1_select;
    src_sel_t               alu_src2_select;
    logic                   ex_slot_valid;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_load, id_is_in, flush,
        input  stall, alu_src1_select, alu_src2_select, ex_slot_valid, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_load, id_is_in, flush,
        output stall, alu_src1_select, alu_src2_select, ex_slot_valid, stall_count
    );

endinterface

// File: rtl/forward_hazard_unit_fwd_select.sv
// Per-operand forwarding select from the EX (1 ahead) and MEM (2 ahead) scoreboard slots.
module fwd_select
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_used,
    input  sb_slot_t              i_ex_slot,
    input  sb_slot_t              i_mem_slot,
    output src_sel_t              o_select,
    output logic                  o_ex_load_hit
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_used & i_ex_slot.valid & i_ex_slot.writes_rd &
                       (i_ex_slot.rd == i_src);
    assign w_mem_hit = i_used & i_mem_slot.valid & i_mem_slot.writes_rd &
                       (i_mem_slot.rd == i_src);

    assign o_ex_load_hit = w_ex_hit & i_ex_slot.is_load;

    always_comb begin
        o_select = SRC_REGFILE;
        if (w_ex_hit && i_ex_slot.is_in) begin
            o_select = SRC_EX_IN;
        end else if (w_ex_hit && !i_ex_slot.is_load) begin
            o_select = SRC_EX_ALU;
        end else if (w_mem_hit) begin
            // Load data and ALU results both arrive on the write-back bus; only IN differs.
            case ({i_mem_slot.is_in, i_mem_slot.is_load})
                2'b10, 2'b11: o_select = SRC_MEM_IN;
                default:      o_select = SRC_WB;
            endcase
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding scoreboard, load-use stall request and ID/EX select registers.
module forward_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    forward_hazard_unit_if.slave bus
);

    // Producers three or more ahead are served by the negedge regfile write,
    // so only the EX and MEM slots carry forwarding state.
    sb_slot_t               r_ex;
    sb_slot_t               r_mem;
    src_sel_t               r_src1_select;
    src_sel_t               r_src2_select;
    logic [STALL_CNT_W-1:0] r_stall_count;

    sb_slot_t w_id_slot;
    src_sel_t w_src1_select;
    src_sel_t w_src2_select;
    logic     w_rs1_load_hit;
    logic     w_rs2_load_hit;
    logic     w_stall;
    logic     w_advance;
    logic     w_cnt_sat;

    fwd_select u_fwd_rs1 (
        .i_src         (bus.id_rs1),
        .i_used        (bus.id_uses_rs1),
        .i_ex_slot     (r_ex),
        .i_mem_slot    (r_mem),
        .o_select      (w_src1_select),
        .o_ex_load_hit (w_rs1_load_hit)
    );

    fwd_select u_fwd_rs2 (
        .i_src         (bus.id_rs2),
        .i_used        (bus.id_uses_rs2),
        .i_ex_slot     (r_ex),
        .i_mem_slot    (r_mem),
        .o_select      (w_src2_select),
        .o_ex_load_hit (w_rs2_load_hit)
    );

    assign w_stall   = bus.id_valid & ~bus.flush & (w_rs1_load_hit | w_rs2_load_hit);
    assign w_advance = bus.id_valid & ~w_stall & ~bus.flush;
    assign w_cnt_sat = &r_stall_count;

    always_comb begin
        w_id_slot           = '0;
        w_id_slot.valid     = 1'b1;
        w_id_slot.rd        = bus.id_rd;
        w_id_slot.writes_rd = bus.id_writes_rd;
        w_id_slot.is_load   = bus.id_is_load;
        w_id_slot.is_in     = bus.id_is_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_src1_select <= SRC_REGFILE;
            r_src2_select <= SRC_REGFILE;
        end else begin
            r_mem <= r_ex;
            if (w_advance) begin
                r_ex          <= w_id_slot;
                r_src1_select <= w_src1_select;
                r_src2_select <= w_src2_select;
            end else begin
                r_ex          <= '0;
                r_src1_select <= SRC_REGFILE;
                r_src2_select <= SRC_REGFILE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && !w_cnt_sat) begin
            r_stall_count <= r_stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.stall           = w_stall;
    assign bus.alu_src1_select = r_src1_select;
    assign bus.alu_src2_select = r_src2_select;
    assign bus.ex_slot_valid   = r_ex.valid;
    assign bus.stall_count     = r_stall_count;

endmodule
